hex_scroller: RTL and testbench

Parametrised scrolling-message driver for a bank of 7-segment displays. It generalises the fixed 4-digit "FPGA" marquee. Digit count, message length, glyph content, blank gap, step period and output polarity are all parameters. At run time it adds scroll direction, a 1x/2x/4x/8x speed select, pause/hold and a run/blank control. It sits between board-level switches and the HEX pins in board tops.

---
 rtl/hex_pkg.sv | 34 +++
 rtl/tick_divider.sv | 46 ++++
 rtl/hex_scroller.sv | 155 +++++++++++++++
 tb/tb_hex_scroller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// Shared definitions for the 7-segment scroller family.
//   - Active-high glyph constants (bit 0 = segment a ... bit 6 = segment g, bit 7 = dp).
//   - Scroller FSM state encoding.
//   - seg_drive(): maps an active-high glyph to the board's pin polarity.
package hex_pkg;

  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_P     = 8'h73;
  localparam logic [7:0] SEG_G     = 8'h7D;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    HOLD
  } state_e;

  function automatic logic [7:0] seg_drive(input logic [7:0] glyph, input logic active_low);
    return active_low ? ~glyph : glyph;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable step-rate divider.
//   CLOCK_50 : clock
//   RST      : synchronous active-high clear of the count
//   en       : 1 = count, 0 = hold the count (and suppress tick)
//   shift    : period = TICK_DIV >> shift cycles
//   tick     : combinational, high in the last cycle of each period
// The terminal compare is >= so a shorter period selected mid-count fires on
// the next cycle instead of waiting for the counter to wrap.
module tick_divider #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       en,
  input  logic [1:0] shift,
  output logic       tick
);

  localparam int unsigned CW = $clog2(TICK_DIV) + 1;
  localparam logic [CW-1:0] DIV = CW'(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period, last;

  assign period = DIV >> shift;
  assign last   = period - CW'(1);
  assign tick   = en && (cnt_q >= last);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_scroller.sv
// Scrolling-message driver for a bank of 7-segment digits.
//   CLOCK_50 : clock
//   RST      : synchronous active-high reset
//   RUN      : 1 = show/scroll message, 0 = blank display and rewind
//   DIR      : 0 = text moves toward HEX0, 1 = toward the leftmost digit
//   PAUSE    : 1 = freeze display and step divider
//   SPEED    : step period = TICK_DIV >> SPEED
//   HEX      : registered segment bus, leftmost digit in the top byte
//   STEP     : registered one-cycle pulse per accepted step
// The message plus GAP blanks forms a circular sequence of P entries; pos
// selects the rotation. Per-digit indices are formed from a constant d mod P
// plus one add/subtract and a single conditional wrap, so P can be any size.
module hex_scroller import hex_pkg::*; #(
  parameter int unsigned          NUM_DIGITS = 4,
  parameter int unsigned          MSG_LEN    = 4,
  parameter logic [8*MSG_LEN-1:0] MSG        = {SEG_F, SEG_P, SEG_G, SEG_A},
  parameter int unsigned          GAP        = 1,
  parameter int unsigned          TICK_DIV   = 50000000,
  parameter bit                   ACTIVE_LOW = 1'b1
) (
  input  logic                    CLOCK_50,
  input  logic                    RST,
  input  logic                    RUN,
  input  logic                    DIR,
  input  logic                    PAUSE,
  input  logic [1:0]              SPEED,
  output logic [8*NUM_DIGITS-1:0] HEX,
  output logic                    STEP
);

  localparam int unsigned P  = MSG_LEN + GAP;
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  // One spare bit so d + pos (at most 2P-2) never overflows before the wrap.
  localparam int unsigned IW = PW + 1;
  localparam logic [IW-1:0] P_IW   = IW'(P);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [8*NUM_DIGITS-1:0] HEX_BLANK =
    {NUM_DIGITS{seg_drive(SEG_BLANK, ACTIVE_LOW)}};

  state_e state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, pos_inc;
  logic [8*NUM_DIGITS-1:0] hex_q, hex_d, frame;
  logic step_q, step_d;
  logic tick;

  // Divider is held cleared while stopped so every start waits a full period.
  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .CLOCK_50(CLOCK_50),
    .RST     (RST | ~RUN),
    .en      (~PAUSE),
    .shift   (SPEED),
    .tick    (tick)
  );

  // Extended sequence: glyphs first, then GAP blank slots.
  logic [7:0] seq [P];
  for (genvar i = 0; i < P; i++) begin : g_seq
    if (i < MSG_LEN) begin : g_glyph
      assign seq[i] = MSG[8*(MSG_LEN-1-i) +: 8];
    end else begin : g_gap
      assign seq[i] = SEG_BLANK;
    end
  end

  // Frame for the next position; digit 0 is the leftmost byte.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    localparam logic [IW-1:0] DM = IW'(d % P);
    logic [IW-1:0] pos_w, idx_r, idx_l_raw, idx_l;
    logic [PW-1:0] idx;

    assign pos_w     = {1'b0, pos_d};
    assign idx_r     = (DM >= pos_w) ? DM - pos_w : DM + P_IW - pos_w;
    assign idx_l_raw = DM + pos_w;
    assign idx_l     = (idx_l_raw >= P_IW) ? idx_l_raw - P_IW : idx_l_raw;
    assign idx       = PW'(DIR ? idx_l : idx_r);

    assign frame[8*(NUM_DIGITS-1-d) +: 8] = seg_drive(seq[idx], ACTIVE_LOW);
  end

  assign pos_inc = (pos_q == P_LAST) ? '0 : pos_q + PW'(1);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    step_d  = 1'b0;

    if (!RUN) begin
      state_d = IDLE;
      pos_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // First tick shows the unshifted message without advancing.
          if (tick) begin
            state_d = SCROLL;
            pos_d   = '0;
            step_d  = 1'b1;
          end
        end
        SCROLL: begin
          if (PAUSE) begin
            state_d = HOLD;
          end else if (tick) begin
            pos_d  = pos_inc;
            step_d = 1'b1;
          end
        end
        HOLD: begin
          // The divider kept its count, so a tick on the release cycle is honoured.
          if (!PAUSE) begin
            state_d = SCROLL;
            if (tick) begin
              pos_d  = pos_inc;
              step_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          pos_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    hex_d = frame;
    if (state_d == IDLE) begin
      hex_d = HEX_BLANK;
    end else if (state_d == HOLD) begin
      // Frozen frame; a DIR change while held waits for the release.
      hex_d = hex_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q <= IDLE;
      pos_q   <= '0;
      step_q  <= 1'b0;
      hex_q   <= HEX_BLANK;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      hex_q   <= hex_d;
    end
  end

  assign HEX  = hex_q;
  assign STEP = step_q;

endmodule

// File: tb/tb_hex_scroller.sv
module tb_hex_scroller;

  logic        clk;
  logic        rst;
  logic        run;
  logic        dir;
  logic        pause;
  logic [1:0]  speed;
  logic [31:0] hex;
  logic        step;

  int checks = 0;
  int errors = 0;

  hex_scroller #(
    .NUM_DIGITS(4),
    .MSG_LEN   (4),
    .MSG       (32'h71737D77),
    .GAP       (1),
    .TICK_DIV  (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLOCK_50(clk),
    .RST     (rst),
    .RUN     (run),
    .DIR     (dir),
    .PAUSE   (pause),
    .SPEED   (speed),
    .HEX     (hex),
    .STEP    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dir = 1'b0; pause = 1'b0; speed = 2'd0;
    cyc(2);
    chk("reset_hex", hex, 32'hFFFFFFFF);
    chk("reset_step", 32'(step), 32'd0);

    // Start: blank for three cycles, first frame on the 4th edge.
    rst = 1'b0; run = 1'b1;
    cyc(3);
    chk("start_blank", hex, 32'hFFFFFFFF);
    chk("start_nostep", 32'(step), 32'd0);
    cyc(1);
    chk("first_frame", hex, 32'h8E8C8288);
    chk("first_step", 32'(step), 32'd1);
    cyc(1);
    chk("step_pulse_end", 32'(step), 32'd0);

    // Rightward scroll through a full wrap.
    cyc(3);
    chk("right_pos1", hex, 32'hFF8E8C82);
    chk("right_pos1_step", 32'(step), 32'd1);
    cyc(3);
    chk("right_between", hex, 32'hFF8E8C82);
    chk("right_between_step", 32'(step), 32'd0);
    cyc(1);
    chk("right_pos2", hex, 32'h88FF8E8C);
    cyc(4);
    chk("right_pos3", hex, 32'h8288FF8E);
    cyc(4);
    chk("right_pos4", hex, 32'h8C8288FF);
    cyc(4);
    chk("right_wrap_pos0", hex, 32'h8E8C8288);

    // Leftward from pos 0.
    dir = 1'b1;
    cyc(4);
    chk("left_pos1", hex, 32'h8C8288FF);
    chk("left_pos1_step", 32'(step), 32'd1);
    cyc(4);
    chk("left_pos2", hex, 32'h8288FF8E);

    // Pause: display frozen, no steps.
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("pause_hex", hex, 32'h8288FF8E);
      chk("pause_step", 32'(step), 32'd0);
    end

    // Release at SPEED=2 (period 1): a step every cycle.
    pause = 1'b0; speed = 2'd2;
    cyc(1);
    chk("fast_pos3", hex, 32'h88FF8E8C);
    chk("fast_step0", 32'(step), 32'd1);
    cyc(1);
    chk("fast_pos4", hex, 32'hFF8E8C82);
    chk("fast_step1", 32'(step), 32'd1);
    cyc(1);
    chk("fast_pos0", hex, 32'h8E8C8288);
    chk("fast_step2", 32'(step), 32'd1);

    // Back to SPEED=0 with the count at 0: next step 4 cycles later.
    speed = 2'd0;
    cyc(3);
    chk("slow_wait_step", 32'(step), 32'd0);
    chk("slow_wait_hex", hex, 32'h8E8C8288);
    cyc(1);
    chk("slow_step", 32'(step), 32'd1);
    chk("slow_pos1", hex, 32'h8C8288FF);
    cyc(4);
    chk("left_pos2b", hex, 32'h8288FF8E);
    cyc(4);
    chk("left_pos3", hex, 32'h88FF8E8C);

    // RUN drop at pos 3 blanks on the next edge.
    run = 1'b0;
    cyc(1);
    chk("run_drop_hex", hex, 32'hFFFFFFFF);
    chk("run_drop_step", 32'(step), 32'd0);
    cyc(5);
    chk("run_off_hex", hex, 32'hFFFFFFFF);

    // Restart rewinds to the unshifted message.
    run = 1'b1;
    cyc(3);
    chk("restart_blank", hex, 32'hFFFFFFFF);
    cyc(1);
    chk("restart_frame", hex, 32'h8E8C8288);
    chk("restart_step", 32'(step), 32'd1);

    // Reset coincident with tick and pause, one step into the scroll.
    cyc(3);
    rst = 1'b1; pause = 1'b1;
    cyc(1);
    chk("rst_prio_hex", hex, 32'hFFFFFFFF);
    chk("rst_prio_step", 32'(step), 32'd0);

    // pos must be 0 after reset: next first frame is unshifted.
    rst = 1'b0; pause = 1'b0;
    cyc(3);
    chk("post_rst_blank", hex, 32'hFFFFFFFF);
    cyc(1);
    chk("post_rst_frame", hex, 32'h8E8C8288);
    chk("post_rst_step", 32'(step), 32'd1);
    cyc(4);
    chk("post_rst_pos1", hex, 32'h8C8288FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
